// File: rtl/escritura_memoria_to_registro.sv
// escritura_memoria_to_registro: bus write stage latching NN coefficients and sequencing start/busy/done/error.
module escritura_memoria_to_registro #(
  parameter int Width      = 4,
  parameter int TimeoutCyc = 1023,
  parameter int CntWidth   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Write,
  input  logic             Read,
  input  logic [8:0]       Address,
  input  logic [Width-1:0] InDatoBus,
  input  logic             ListoRed,
  input  logic             ErrorRed,
  output logic [Width-1:0] Coeff00,
  output logic [Width-1:0] Coeff01,
  output logic [Width-1:0] Coeff02,
  output logic [Width-1:0] Coeff03,
  output logic [Width-1:0] Coeff04,
  output logic [Width-1:0] Coeff05,
  output logic [Width-1:0] Coeff06,
  output logic [Width-1:0] Coeff07,
  output logic [Width-1:0] Coeff08,
  output logic [Width-1:0] Coeff09,
  output logic [Width-1:0] Coeff10,
  output logic [Width-1:0] Coeff11,
  output logic [Width-1:0] Coeff12,
  output logic [Width-1:0] Coeff13,
  output logic [Width-1:0] Coeff14,
  output logic [Width-1:0] Coeff15,
  output logic [Width-1:0] Coeff16,
  output logic [Width-1:0] Coeff17,
  output logic [Width-1:0] Coeff18,
  output logic [Width-1:0] Coeff19,
  output logic [Width-1:0] Offset,
  output logic [Width-1:0] DatoEntradaSistema,
  output logic             Start,
  output logic             Busy,
  output logic             ListoOut,
  output logic             ErrorOut
);
  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
  state_t state, nxt;
  logic [CntWidth-1:0] cnt;
  logic [Width-1:0] regs [22];
  logic [4:0] idx;
  logic idle, data_wr, cmd_wr, done, timeout, listo_clr, error_set, error_clr;
  // regs[0..19] coefficients, regs[20] offset, regs[21] system input; one word per 4 bytes from 0x00C
  always_comb begin
    idle      = state == IDLE;
    idx       = 5'((Address - 9'h00C) >> 2);
    data_wr   = Write && Address >= 9'h00C && Address <= 9'h060 && Address[1:0] == 2'b00;
    cmd_wr    = Write && Address == 9'h000 && InDatoBus[0];
    done      = state == BUSY && ListoRed;
    timeout   = state == BUSY && !ListoRed && cnt == CntWidth'(TimeoutCyc - 1);
    listo_clr = (Read && Address == 9'h004) || (idle && cmd_wr);
    error_set = ErrorRed || timeout || (!idle && (data_wr || cmd_wr));
    error_clr = Write && Address == 9'h008;
    nxt       = state == START ? BUSY : (idle && cmd_wr) ? START : (done || timeout) ? IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      Start    <= 1'b0;
      Busy     <= 1'b0;
      ListoOut <= 1'b0;
      ErrorOut <= 1'b0;
      for (int i = 0; i < 22; i++) regs[i] <= '0;
    end else begin
      if (data_wr && idle) regs[idx] <= InDatoBus;
      state    <= nxt;
      cnt      <= state == BUSY ? cnt + 1'b1 : '0;
      Start    <= nxt == START;
      Busy     <= nxt != IDLE;
      ListoOut <= done || (!listo_clr && ListoOut);
      ErrorOut <= error_set || (!error_clr && ErrorOut);
    end
  end
  assign Coeff00 = regs[0];
  assign Coeff01 = regs[1];
  assign Coeff02 = regs[2];
  assign Coeff03 = regs[3];
  assign Coeff04 = regs[4];
  assign Coeff05 = regs[5];
  assign Coeff06 = regs[6];
  assign Coeff07 = regs[7];
  assign Coeff08 = regs[8];
  assign Coeff09 = regs[9];
  assign Coeff10 = regs[10];
  assign Coeff11 = regs[11];
  assign Coeff12 = regs[12];
  assign Coeff13 = regs[13];
  assign Coeff14 = regs[14];
  assign Coeff15 = regs[15];
  assign Coeff16 = regs[16];
  assign Coeff17 = regs[17];
  assign Coeff18 = regs[18];
  assign Coeff19 = regs[19];
  assign Offset = regs[20];
  assign DatoEntradaSistema = regs[21];
endmodule

// File: tb/tb_escritura_memoria_to_registro.sv
// tb_escritura_memoria_to_registro: randomized bench against a job-age reference model plus directed checks.
module tb_escritura_memoria_to_registro;
  localparam int W = 8;
  localparam int T = 8;
  logic clk = 0, rst = 1, wr = 0, rd = 0, lr = 0, er = 0;
  logic [8:0] addr = 0;
  logic [W-1:0] din = 0;
  logic [W-1:0] co [20];
  logic [W-1:0] offs, dato;
  logic st, busy, listo, err;
  int n_cmp = 0, n_fail = 0;
  bit chk = 0;
  // model: age -1 = no job, 0 = start cycle, k>=1 = k-th busy cycle
  int age, m_regs [22];
  bit m_listo, m_err;
  always #5 clk = ~clk;
  escritura_memoria_to_registro #(.Width(W), .TimeoutCyc(T), .CntWidth(10)) dut (
    .CLK(clk), .RST(rst), .Write(wr), .Read(rd), .Address(addr), .InDatoBus(din),
    .ListoRed(lr), .ErrorRed(er),
    .Coeff00(co[0]), .Coeff01(co[1]), .Coeff02(co[2]), .Coeff03(co[3]), .Coeff04(co[4]),
    .Coeff05(co[5]), .Coeff06(co[6]), .Coeff07(co[7]), .Coeff08(co[8]), .Coeff09(co[9]),
    .Coeff10(co[10]), .Coeff11(co[11]), .Coeff12(co[12]), .Coeff13(co[13]), .Coeff14(co[14]),
    .Coeff15(co[15]), .Coeff16(co[16]), .Coeff17(co[17]), .Coeff18(co[18]), .Coeff19(co[19]),
    .Offset(offs), .DatoEntradaSistema(dato),
    .Start(st), .Busy(busy), .ListoOut(listo), .ErrorOut(err)
  );
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    bit locked, go, ls, lc, es, ec;
    if (rst) begin
      age = -1; m_listo = 0; m_err = 0;
      for (int i = 0; i < 22; i++) m_regs[i] = 0;
    end else begin
      locked = age >= 0;
      go = wr && addr == 0 && din[0];
      es = er || (locked && go);
      if (wr && addr >= 12 && addr <= 96 && addr % 4 == 0) begin
        if (locked) es = 1;
        else m_regs[(int'(addr) - 12) / 4] = int'(din);
      end
      ls = age >= 1 && lr;
      if (age == T && !lr) es = 1;
      lc = (rd && addr == 4) || (!locked && go);
      ec = wr && addr == 8;
      if (!locked && go) age = 0;
      else if (age >= 1 && (lr || age == T)) age = -1;
      else if (age >= 0) age = age + 1;
      m_listo = ls ? 1 : lc ? 0 : m_listo;
      m_err = es ? 1 : ec ? 0 : m_err;
    end
  end
  always @(negedge clk) if (chk) begin
    for (int i = 0; i < 20; i++) check($sformatf("coeff%0d", i), int'(co[i]), m_regs[i]);
    check("offset", int'(offs), m_regs[20]);
    check("dato", int'(dato), m_regs[21]);
    check("start", int'(st), int'(age == 0));
    check("busy", int'(busy), int'(age >= 0));
    check("listo", int'(listo), int'(m_listo));
    check("error", int'(err), int'(m_err));
  end
  task automatic drive(input bit r, input bit w, input bit rr, input int a, input int d, input bit l, input bit e);
    @(posedge clk); #1;
    rst = r; wr = w; rd = rr; addr = 9'(a); din = W'(d); lr = l; er = e;
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int bc;
    drive(1, 0, 0, 0, 0, 0, 0);
    nop();
    chk = 1;
    check("rst_busy", int'(busy), 0);
    check("rst_coeff00", int'(co[0]), 0);
    for (int k = 0; k < 22; k++) drive(0, 1, 0, 12 + 4 * k, k + 1, 0, 0);
    nop();
    check("t1_coeff00", int'(co[0]), 1);
    check("t1_coeff19", int'(co[19]), 20);
    check("t1_offset", int'(offs), 21);
    check("t1_dato", int'(dato), 22);
    drive(0, 1, 0, 0, 1, 0, 0);
    nop();
    check("t2_start_hi", int'(st), 1);
    check("t2_busy_hi", int'(busy), 1);
    nop();
    check("t2_start_lo", int'(st), 0);
    check("t2_busy_still", int'(busy), 1);
    repeat (3) nop();
    drive(0, 0, 0, 0, 0, 1, 0);
    nop();
    check("t2_busy_done", int'(busy), 0);
    check("t2_listo_set", int'(listo), 1);
    drive(0, 0, 1, 4, 0, 0, 0);
    nop();
    check("t2_listo_clr", int'(listo), 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    nop();
    drive(0, 1, 0, 16, 7, 0, 0);
    nop();
    check("t3_coeff01_kept", int'(co[1]), 2);
    check("t3_err_lock", int'(err), 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 0, 8, 0, 0, 0);
    nop();
    check("t3_err_clr", int'(err), 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      nop();
      if (busy) bc++;
    end
    check("t4_busy_cycles", bc, T + 1);
    check("t4_err_timeout", int'(err), 1);
    check("t4_listo_zero", int'(listo), 0);
    drive(0, 1, 0, 8, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    nop();
    drive(0, 0, 1, 4, 0, 1, 0);
    nop();
    check("t5_listo_set_wins", int'(listo), 1);
    drive(0, 1, 0, 8, 0, 0, 1);
    nop();
    check("t5_err_set_wins", int'(err), 1);
    drive(0, 1, 0, 8, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    nop();
    nop();
    drive(1, 0, 0, 0, 0, 0, 0);
    nop();
    check("t6_busy_rst", int'(busy), 0);
    check("t6_start_rst", int'(st), 0);
    check("t6_coeff00_rst", int'(co[0]), 0);
    check("t6_dato_rst", int'(dato), 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    nop();
    check("t6_listo_ignored", int'(listo), 0);
    check("t6_busy_ignored", int'(busy), 0);
    for (int i = 0; i < 3000; i++) begin
      int sel, a, d;
      sel = $urandom_range(0, 9);
      a = sel <= 4 ? 12 + 4 * $urandom_range(0, 21) : sel == 5 ? 0 : sel == 6 ? 4 :
          sel == 7 ? 8 : sel == 8 ? $urandom_range(0, 511) : 13 + 4 * $urandom_range(0, 20);
      d = $urandom_range(0, 255);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            a, d, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
    end
    nop();
    nop();
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
